cond_eval: RTL and testbench

Condition-code evaluator that consumes the {N, Z, C, V} flags produced by the compare/ALU path and resolves 4-bit condition fields for conditional instructions and branches. Holds the architectural flags register, tracks an outstanding flag-setting instruction, forwards same-cycle flag writes, and returns a registered taken/not-taken result through a valid/ready handshake. Sits between the ALU flag output and the branch/predication logic of the 32-bit datapath.

---
 rtl/cond_eval_pkg.sv | 37 +++
 rtl/cond_decode.sv | 43 ++++
 rtl/cond_eval.sv | 88 ++++++++
 tb/tb_cond_eval.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cond_eval_pkg.sv
// Shared definitions for the condition-code evaluator and its decoder.
package cond_eval_pkg;

   localparam int unsigned COND_W = 4;
   localparam int unsigned FLAG_W = 4;

   // Condition codes (C is a borrow flag: set when in1 < in2 unsigned)
   localparam logic [COND_W-1:0] COND_EQ = 4'd0;
   localparam logic [COND_W-1:0] COND_NE = 4'd1;
   localparam logic [COND_W-1:0] COND_LO = 4'd2;
   localparam logic [COND_W-1:0] COND_HS = 4'd3;
   localparam logic [COND_W-1:0] COND_MI = 4'd4;
   localparam logic [COND_W-1:0] COND_PL = 4'd5;
   localparam logic [COND_W-1:0] COND_VS = 4'd6;
   localparam logic [COND_W-1:0] COND_VC = 4'd7;
   localparam logic [COND_W-1:0] COND_HI = 4'd8;
   localparam logic [COND_W-1:0] COND_LS = 4'd9;
   localparam logic [COND_W-1:0] COND_GE = 4'd10;
   localparam logic [COND_W-1:0] COND_LT = 4'd11;
   localparam logic [COND_W-1:0] COND_GT = 4'd12;
   localparam logic [COND_W-1:0] COND_LE = 4'd13;
   localparam logic [COND_W-1:0] COND_AL = 4'd14;
   localparam logic [COND_W-1:0] COND_NV = 4'd15;

   // Bit positions inside the {N, Z, C, V} flag vector
   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   // Flag-register validity tracking
   typedef enum logic {
      F_VALID = 1'b0,
      F_PEND  = 1'b1
   } flag_state_t;

endpackage

// File: rtl/cond_decode.sv
// Combinational condition-code resolver shared with the predication path.
module cond_decode
   import cond_eval_pkg::*;
(
   input  logic [COND_W-1:0] cond,
   input  logic [FLAG_W-1:0] flags,
   output logic              taken
);

   logic n;
   logic z;
   logic c;
   logic v;

   assign n = flags[FLAG_N];
   assign z = flags[FLAG_Z];
   assign c = flags[FLAG_C];
   assign v = flags[FLAG_V];

   // Resolve the condition against the supplied flags
   always_comb begin
      taken = 1'b0;
      case (cond)
         COND_EQ: taken = z;
         COND_NE: taken = !z;
         COND_LO: taken = c;
         COND_HS: taken = !c;
         COND_MI: taken = n;
         COND_PL: taken = !n;
         COND_VS: taken = v;
         COND_VC: taken = !v;
         COND_HI: taken = !c && !z;
         COND_LS: taken = c || z;
         COND_GE: taken = (n == v);
         COND_LT: taken = (n != v);
         COND_GT: taken = !z && (n == v);
         COND_LE: taken = z || (n != v);
         COND_AL: taken = 1'b1;
         COND_NV: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_eval.sv
// Condition evaluator: flags register, pending-flag interlock, forwarding,
// registered taken/not-taken response with valid/ready and statistics.
module cond_eval
   import cond_eval_pkg::*;
#(
   parameter int unsigned TAG_W = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [FLAG_W-1:0] flags_in,
   input  logic              flags_we,
   input  logic              flags_pend,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [COND_W-1:0] req_cond,
   input  logic [TAG_W-1:0]  req_tag,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic              resp_taken,
   output logic [TAG_W-1:0]  resp_tag,
   output logic [FLAG_W-1:0] flags_q,
   output logic [CNT_W-1:0]  eval_cnt,
   output logic [CNT_W-1:0]  taken_cnt
);

   flag_state_t       state;
   logic [FLAG_W-1:0] eff_flags_c;
   logic              taken_c;
   logic              out_free_c;
   logic              accept_c;
   logic              resp_fire_c;

   // A same-cycle flag write is forwarded to the request being evaluated
   assign eff_flags_c = flags_we ? flags_in : flags_q;
   assign out_free_c  = !resp_valid || resp_ready;
   // While flags are pending only a cycle that delivers them may evaluate
   assign req_ready   = out_free_c && ((state == F_VALID) || flags_we);
   assign accept_c    = req_valid && req_ready;
   assign resp_fire_c = resp_valid && resp_ready;

   cond_decode u_decode (
      .cond  (req_cond),
      .flags (eff_flags_c),
      .taken (taken_c)
   );

   // Flags register, pending FSM, response register and saturating counters
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= F_VALID;
         flags_q    <= '0;
         resp_valid <= 1'b0;
         resp_taken <= 1'b0;
         resp_tag   <= '0;
         eval_cnt   <= '0;
         taken_cnt  <= '0;
      end else begin
         if (flags_we) begin
            flags_q <= flags_in;
         end

         case (state)
            F_VALID: if (flags_pend) state <= F_PEND;
            F_PEND:  if (flags_we && !flags_pend) state <= F_VALID;
            default: state <= F_VALID;
         endcase

         if (accept_c) begin
            resp_valid <= 1'b1;
            resp_taken <= taken_c;
            resp_tag   <= req_tag;
         end else if (resp_fire_c) begin
            resp_valid <= 1'b0;
         end

         if (resp_fire_c) begin
            if (eval_cnt != {CNT_W{1'b1}}) begin
               eval_cnt <= eval_cnt + CNT_W'(1);
            end
            if (resp_taken && (taken_cnt != {CNT_W{1'b1}})) begin
               taken_cnt <= taken_cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_cond_eval.sv
// Self-checking bench for cond_eval: directed scenarios plus random traffic
// against a cycle-level reference model. A second instance with 2-bit
// counters sees the same stimulus to exercise counter saturation.
module tb_cond_eval;

   localparam int unsigned TAG_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic [3:0]       flags_in;
   logic             flags_we;
   logic             flags_pend;
   logic             req_valid;
   logic [3:0]       req_cond;
   logic [TAG_W-1:0] req_tag;
   logic             resp_ready;

   logic             a_req_ready, a_resp_valid, a_resp_taken;
   logic [TAG_W-1:0] a_resp_tag;
   logic [3:0]       a_flags_q;
   logic [15:0]      a_eval_cnt, a_taken_cnt;

   logic             b_req_ready, b_resp_valid, b_resp_taken;
   logic [TAG_W-1:0] b_resp_tag;
   logic [3:0]       b_flags_q;
   logic [1:0]       b_eval_cnt, b_taken_cnt;

   cond_eval #(.TAG_W(TAG_W), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .flags_in(flags_in), .flags_we(flags_we),
      .flags_pend(flags_pend), .req_valid(req_valid), .req_ready(a_req_ready),
      .req_cond(req_cond), .req_tag(req_tag), .resp_valid(a_resp_valid),
      .resp_ready(resp_ready), .resp_taken(a_resp_taken), .resp_tag(a_resp_tag),
      .flags_q(a_flags_q), .eval_cnt(a_eval_cnt), .taken_cnt(a_taken_cnt)
   );

   cond_eval #(.TAG_W(TAG_W), .CNT_W(2)) dut_s (
      .clk(clk), .reset(reset), .flags_in(flags_in), .flags_we(flags_we),
      .flags_pend(flags_pend), .req_valid(req_valid), .req_ready(b_req_ready),
      .req_cond(req_cond), .req_tag(req_tag), .resp_valid(b_resp_valid),
      .resp_ready(resp_ready), .resp_taken(b_resp_taken), .resp_tag(b_resp_tag),
      .flags_q(b_flags_q), .eval_cnt(b_eval_cnt), .taken_cnt(b_taken_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   logic             m_pend;
   logic [3:0]       m_flags;
   logic             m_rv;
   logic             m_taken;
   logic [TAG_W-1:0] m_tag;
   int               m_eval;
   int               m_tkn;
   logic             last_rdy;
   int               e0;

   function automatic logic ref_cond(int c, logic [3:0] f);
      logic n, z, cy, v;
      n  = f[3];
      z  = f[2];
      cy = f[1];
      v  = f[0];
      case (c)
         0:  return z;
         1:  return !z;
         2:  return cy;
         3:  return !cy;
         4:  return n;
         5:  return !n;
         6:  return v;
         7:  return !v;
         8:  return !cy && !z;
         9:  return cy || z;
         10: return n == v;
         11: return n != v;
         12: return !z && (n == v);
         13: return z || (n != v);
         14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic int sat(int val, int max);
      return (val > max) ? max : val;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      flags_we   = 1'b0;
      flags_pend = 1'b0;
      req_valid  = 1'b0;
      resp_ready = 1'b1;
   endtask

   // One clock: check acceptance, advance model across the edge, check outputs
   task automatic step();
      logic       rdy, acc, fire;
      logic [3:0] eff;
      #1;
      rdy      = (!m_rv || resp_ready) && (!m_pend || flags_we);
      last_rdy = a_req_ready;
      if (!reset) begin
         chk("req_ready", a_req_ready, rdy);
         chk("req_ready_s", b_req_ready, rdy);
      end
      acc  = req_valid && rdy;
      fire = m_rv && resp_ready;
      eff  = flags_we ? flags_in : m_flags;
      @(posedge clk);
      #1;
      if (reset) begin
         m_pend = 0; m_flags = 0; m_rv = 0; m_taken = 0; m_tag = 0;
         m_eval = 0; m_tkn = 0;
      end else begin
         if (fire) begin
            m_eval++;
            if (m_taken) m_tkn++;
         end
         if (acc) begin
            m_rv    = 1'b1;
            m_taken = ref_cond(int'(req_cond), eff);
            m_tag   = req_tag;
         end else if (fire) begin
            m_rv = 1'b0;
         end
         if (flags_we) m_flags = flags_in;
         if (m_pend) begin
            if (flags_we && !flags_pend) m_pend = 1'b0;
         end else if (flags_pend) begin
            m_pend = 1'b1;
         end
      end
      chk("resp_valid", a_resp_valid, m_rv);
      chk("resp_taken", a_resp_taken, m_taken);
      chk("resp_tag", a_resp_tag, m_tag);
      chk("flags_q", a_flags_q, m_flags);
      chk("eval_cnt", a_eval_cnt, sat(m_eval, 65535));
      chk("taken_cnt", a_taken_cnt, sat(m_tkn, 65535));
      chk("resp_valid_s", b_resp_valid, m_rv);
      chk("eval_cnt_s", b_eval_cnt, sat(m_eval, 3));
      chk("taken_cnt_s", b_taken_cnt, sat(m_tkn, 3));
   endtask

   initial begin
      m_pend = 0; m_flags = 0; m_rv = 0; m_taken = 0; m_tag = 0;
      m_eval = 0; m_tkn = 0; last_rdy = 0; e0 = 0;
      flags_in = 4'h0; req_cond = 4'h0; req_tag = '0;
      idle();

      // Reset
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      chk("rst_resp_valid", a_resp_valid, 0);
      chk("rst_flags", a_flags_q, 0);
      chk("rst_eval", a_eval_cnt, 0);
      #1 chk("rst_ready", a_req_ready, 1);

      // Registered flags: EQ taken, NE not taken
      flags_we = 1'b1; flags_in = 4'b0100;
      step();
      flags_we = 1'b0;
      req_valid = 1'b1; req_cond = 4'd0; req_tag = 4'd3;
      step();
      chk("eq_taken", a_resp_taken, 1);
      chk("eq_tag", a_resp_tag, 3);
      req_cond = 4'd1; req_tag = 4'd4;
      step();
      chk("ne_taken", a_resp_taken, 0);
      req_valid = 1'b0;

      // Same-cycle forwarding
      flags_we = 1'b1; flags_in = 4'b0000;
      step();
      chk("fwd_base_flags", a_flags_q, 0);
      flags_in = 4'b0010; req_valid = 1'b1; req_cond = 4'd2; req_tag = 4'd5;
      step();
      chk("lo_fwd_taken", a_resp_taken, 1);
      chk("fwd_flags", a_flags_q, 4'b0010);
      flags_we = 1'b0; req_cond = 4'd8; req_tag = 4'd6;
      step();
      chk("hi_taken", a_resp_taken, 0);
      req_valid = 1'b0;
      step();

      // Pending-flag stall
      flags_pend = 1'b1;
      step();
      flags_pend = 1'b0;
      req_valid = 1'b1; req_cond = 4'd10; req_tag = 4'd7;
      repeat (3) begin
         step();
         chk("pend_stall", last_rdy, 0);
      end
      flags_we = 1'b1; flags_in = 4'b1001;
      step();
      chk("pend_accept", last_rdy, 1);
      chk("pend_taken", a_resp_taken, 1);
      chk("pend_tag", a_resp_tag, 7);
      flags_we = 1'b0; req_valid = 1'b0;
      step();

      // Backpressure
      req_valid = 1'b1; req_cond = 4'd14; req_tag = 4'd9;
      step();
      resp_ready = 1'b0; req_cond = 4'd15; req_tag = 4'd10;
      e0 = m_eval;
      repeat (4) begin
         step();
         chk("bp_ready", last_rdy, 0);
         chk("bp_tag", a_resp_tag, 9);
         chk("bp_taken", a_resp_taken, 1);
         chk("bp_cnt", a_eval_cnt, e0);
      end
      resp_ready = 1'b1;
      step();
      chk("bp_release_cnt", a_eval_cnt, e0 + 1);
      chk("bp_next_tag", a_resp_tag, 10);
      chk("bp_next_taken", a_resp_taken, 0);
      req_valid = 1'b0;
      step();

      // Full sweep of codes x flags, flags forwarded each cycle
      req_valid = 1'b1; flags_we = 1'b1;
      for (int f = 0; f < 16; f++) begin
         for (int c = 0; c < 16; c++) begin
            flags_in = 4'(f); req_cond = 4'(c); req_tag = 4'(c);
            step();
            if (c == 14) chk("sweep_al", a_resp_taken, 1);
            if (c == 15) chk("sweep_nv", a_resp_taken, 0);
         end
      end
      idle();
      step();

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         reset      = ($urandom_range(0, 63) == 0);
         flags_in   = 4'($urandom_range(0, 15));
         flags_we   = ($urandom_range(0, 2) == 0);
         flags_pend = ($urandom_range(0, 7) == 0);
         req_valid  = ($urandom_range(0, 3) != 0);
         req_cond   = 4'($urandom_range(0, 15));
         req_tag    = TAG_W'($urandom_range(0, 15));
         resp_ready = ($urandom_range(0, 2) != 0);
         step();
      end
      reset = 1'b0;
      idle();

      // Counter saturation on the 2-bit instance
      reset = 1'b1;
      step();
      reset = 1'b0;
      req_valid = 1'b1; req_cond = 4'd14;
      repeat (5) step();
      req_valid = 1'b0;
      step();
      chk("sat_eval_wide", a_eval_cnt, 5);
      chk("sat_taken_wide", a_taken_cnt, 5);
      chk("sat_eval", b_eval_cnt, 3);
      chk("sat_taken", b_taken_cnt, 3);

      // Reset while a response is held
      req_valid = 1'b1; resp_ready = 1'b0;
      step();
      step();
      chk("held_valid", a_resp_valid, 1);
      reset = 1'b1;
      step();
      chk("rst_mid_valid", a_resp_valid, 0);
      chk("rst_mid_cnt", a_eval_cnt, 0);
      chk("rst_mid_cnt_s", b_eval_cnt, 0);
      reset = 1'b0;
      idle();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
